// File: rtl/screen_vram_arbiter.sv
// screen_vram_arbiter: shares the screen VRAM port between the CPU
// memory-mapped path and a linear fill engine (clear-screen, band fills).
module screen_vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [DATA_W-1:0] scr_in,
  output logic              scr_load,
  output logic [ADDR_W-1:0] scr_address,
  input  logic [DATA_W-1:0] scr_out
);

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [1:0]        rd_tag_q, rd_tag_d;

  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;
  logic [DATA_W-1:0] scr_in_q, scr_in_d;
  logic              scr_load_q, scr_load_d;
  logic [ADDR_W-1:0] scr_address_q, scr_address_d;

  logic              cpu_gnt;
  logic              fill_gnt;

  // A CPU grant is refused while its previous ack is still showing,
  // which is what lets the fill engine interleave under CPU saturation.
  always_comb begin
    cpu_gnt  = cpu_req && !cpu_ack_q;
    fill_gnt = !cpu_gnt && (state_q == FILL);
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    val_d         = val_q;
    cpu_ack_d     = 1'b0;
    fill_done_d   = 1'b0;
    scr_load_d    = 1'b0;
    scr_in_d      = scr_in_q;
    scr_address_d = scr_address_q;

    rd_tag_d      = {rd_tag_q[0], cpu_gnt && !cpu_we};
    cpu_rvalid_d  = rd_tag_q[1];
    cpu_rdata_d   = rd_tag_q[1] ? scr_out : cpu_rdata_q;

    unique case (1'b1)
      cpu_gnt: begin
        scr_address_d = cpu_addr;
        scr_load_d    = cpu_we;
        scr_in_d      = cpu_wdata;
        cpu_ack_d     = 1'b1;
      end
      fill_gnt: begin
        scr_address_d = ptr_q;
        scr_load_d    = 1'b1;
        scr_in_d      = val_q;
      end
      default: ;
    endcase

    if (state_q == IDLE) begin
      if (fill_start) begin
        if (fill_len != '0) begin
          state_d = FILL;
          ptr_d   = fill_base;
          rem_d   = fill_len;
          val_d   = fill_value;
        end else begin
          fill_done_d = 1'b1;
        end
      end
    end else if (fill_gnt) begin
      ptr_d = ptr_q + PTR_ONE;
      rem_d = rem_q - REM_ONE;
      if (rem_q == REM_ONE) begin
        state_d     = IDLE;
        fill_done_d = 1'b1;
      end
    end

    fill_busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      rem_q         <= '0;
      val_q         <= '0;
      rd_tag_q      <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      fill_busy_q   <= 1'b0;
      fill_done_q   <= 1'b0;
      scr_in_q      <= '0;
      scr_load_q    <= 1'b0;
      scr_address_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      val_q         <= val_d;
      rd_tag_q      <= rd_tag_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      fill_busy_q   <= fill_busy_d;
      fill_done_q   <= fill_done_d;
      scr_in_q      <= scr_in_d;
      scr_load_q    <= scr_load_d;
      scr_address_q <= scr_address_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign fill_busy   = fill_busy_q;
  assign fill_done   = fill_done_q;
  assign scr_in      = scr_in_q;
  assign scr_load    = scr_load_q;
  assign scr_address = scr_address_q;

endmodule

// File: tb/tb_screen_vram_arbiter.sv
// Bench for screen_vram_arbiter: directed and random traffic against a
// transaction-level model, checked by a queue scoreboard.
module tb_screen_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        fill_start;
  logic [12:0] fill_base;
  logic [13:0] fill_len;
  logic [15:0] fill_value;
  logic        fill_busy, fill_done;
  logic [15:0] scr_in;
  logic        scr_load;
  logic [12:0] scr_address;
  logic [15:0] scr_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int c;
    int a;
    int d;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_rd[$];
  int  q_ack[$];
  int  q_done[$];

  logic [15:0] vram  [8192];
  logic [15:0] m_mem [8192];
  bit          m_busy, m_ack, m_pw, m_cg, m_fg, m_wb;
  int          m_ptr, m_left, m_pa, m_pd, m_val;
  int          wc, wa, wd;

  always #5 clk = ~clk;

  screen_vram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .fill_start(fill_start), .fill_base(fill_base),
    .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .scr_in(scr_in), .scr_load(scr_load),
    .scr_address(scr_address), .scr_out(scr_out)
  );

  // Screen: synchronous write, registered read.
  always @(posedge clk) begin
    if (scr_load) vram[scr_address] <= scr_in;
    scr_out <= vram[scr_address];
  end

  // Reference model: one VRAM slot per edge, CPU first unless it was
  // served last edge; memory contents follow grant order.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_ack = 0; m_pw = 0;
      q_wr.delete(); q_rd.delete();
      q_ack.delete(); q_done.delete();
    end else begin
      cyc++;
      if (m_pw) m_mem[m_pa] = 16'(m_pd);
      m_pw = 0;
      m_wb = m_busy;
      m_cg = cpu_req && !m_ack;
      m_fg = !m_cg && m_busy;
      if (m_cg) begin
        q_ack.push_back(cyc);
        if (cpu_we) begin
          m_pw = 1; m_pa = int'(cpu_addr); m_pd = int'(cpu_wdata);
          q_wr.push_back('{cyc, m_pa, m_pd});
        end else begin
          q_rd.push_back('{cyc + 2, int'(cpu_addr), int'(m_mem[cpu_addr])});
        end
      end else if (m_fg) begin
        m_pw = 1; m_pa = m_ptr; m_pd = m_val;
        q_wr.push_back('{cyc, m_pa, m_pd});
        m_ptr = (m_ptr + 1) % 8192;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0;
          q_done.push_back(cyc);
        end
      end
      if (!m_wb && fill_start) begin
        if (fill_len == 14'd0) q_done.push_back(cyc);
        else begin
          m_busy = 1;
          m_ptr  = int'(fill_base);
          m_left = int'(fill_len);
          m_val  = int'(fill_value);
        end
      end
      m_ack = m_cg;
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      checks++;
      if (fill_busy !== m_busy) begin
        errors++;
        $display("FAIL busy @%0d: got %0b want %0b", cyc, fill_busy, m_busy);
      end
      wc = q_ack.size() != 0 ? q_ack[0] : -1;
      if (cpu_ack) begin
        checks++;
        if (wc != cyc) begin
          errors++;
          $display("FAIL ack @%0d: got ack, next expected at %0d", cyc, wc);
        end
        if (wc != -1 && wc <= cyc) void'(q_ack.pop_front());
      end else if (wc != -1 && wc <= cyc) begin
        checks++; errors++;
        $display("FAIL ack @%0d: got none, want ack at %0d", cyc, wc);
        void'(q_ack.pop_front());
      end
      wc = -1; wa = -1; wd = -1;
      if (q_wr.size() != 0) begin
        wc = q_wr[0].c; wa = q_wr[0].a; wd = q_wr[0].d;
      end
      if (scr_load) begin
        checks++;
        if (wc != cyc || wa != int'(scr_address) || wd != int'(scr_in)) begin
          errors++;
          $display("FAIL write @%0d: got a=0x%0h d=0x%0h want c=%0d a=0x%0h d=0x%0h",
                   cyc, scr_address, scr_in, wc, wa, wd);
        end
        if (wc != -1 && wc <= cyc) void'(q_wr.pop_front());
      end else if (wc != -1 && wc <= cyc) begin
        checks++; errors++;
        $display("FAIL write @%0d: got none want a=0x%0h d=0x%0h", cyc, wa, wd);
        void'(q_wr.pop_front());
      end
      wc = -1; wd = -1;
      if (q_rd.size() != 0) begin
        wc = q_rd[0].c; wd = q_rd[0].d;
      end
      if (cpu_rvalid) begin
        checks++;
        if (wc != cyc || wd != int'(cpu_rdata)) begin
          errors++;
          $display("FAIL read @%0d: got 0x%0h want c=%0d d=0x%0h", cyc, cpu_rdata, wc, wd);
        end
        if (wc != -1 && wc <= cyc) void'(q_rd.pop_front());
      end else if (wc != -1 && wc <= cyc) begin
        checks++; errors++;
        $display("FAIL read @%0d: got no rvalid want d=0x%0h", cyc, wd);
        void'(q_rd.pop_front());
      end
      wc = q_done.size() != 0 ? q_done[0] : -1;
      if (fill_done) begin
        checks++;
        if (wc != cyc) begin
          errors++;
          $display("FAIL done @%0d: got pulse, next expected at %0d", cyc, wc);
        end
        if (wc != -1 && wc <= cyc) void'(q_done.pop_front());
      end else if (wc != -1 && wc <= cyc) begin
        checks++; errors++;
        $display("FAIL done @%0d: got none, want pulse at %0d", cyc, wc);
        void'(q_done.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 0; fill_base = '0; fill_len = '0; fill_value = '0;
  endtask

  function automatic int outs_nonzero();
    return int'(|{cpu_ack, cpu_rdata, cpu_rvalid, fill_busy, fill_done,
                  scr_in, scr_load, scr_address});
  endfunction

  // Starts a fill and counts busy cycles until fill_done. With sync set
  // the start lands on an edge where the CPU cannot be granted.
  task automatic run_fill(input int base, input int len, input int val,
                          input bit sync, input int inj, output int nbusy);
    bit seen = 0;
    bit synced = !sync;
    nbusy = 0;
    @(negedge clk);
    for (int i = 0; i < 10 && !synced; i++) begin
      if (cpu_ack) synced = 1;
      else @(negedge clk);
    end
    if (sync) chk("sync to cpu_ack", int'(synced), 1);
    fill_start = 1;
    fill_base = 13'(base); fill_len = 14'(len); fill_value = 16'(val);
    for (int i = 0; i < 9000 && !seen; i++) begin
      @(negedge clk);
      fill_start = (i == inj);
      fill_base = 13'h1000; fill_len = 14'd2; fill_value = 16'h1234;
      if (fill_busy) nbusy++;
      if (fill_done) seen = 1;
    end
    fill_start = 0;
    chk("fill_done seen", int'(seen), 1);
  endtask

  task automatic cpu_access(input bit we, input int addr, input int data);
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = 13'(addr); cpu_wdata = 16'(data);
    @(negedge clk);
    chk("cpu_ack one edge after req", int'(cpu_ack), 1);
    cpu_req = 0;
    if (!we) begin
      @(negedge clk);
      chk("rvalid not early", int'(cpu_rvalid), 0);
      @(negedge clk);
      chk("rvalid two edges after ack", int'(cpu_rvalid), 1);
      chk("rdata", int'(cpu_rdata), data);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, n, acks, v;
    reset = 0;
    idle_inputs();
    #2 reset = 1;
    #1 chk("outputs zero in reset", outs_nonzero(), 0);
    repeat (3) @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("idle after reset scr_load", int'(scr_load), 0);

    v = int'(16'($urandom));
    run_fill(0, 8192, v, 0, -1, nb);
    chk("full clear busy cycles", nb, 8192);
    @(negedge clk);
    chk("full clear word 0x1234", int'(vram[13'h1234]), v);
    chk("full clear word 0x1fff", int'(vram[13'h1fff]), v);

    cpu_access(1, 'h100, 'hA5A5);
    cpu_access(0, 'h100, 'hA5A5);

    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h100;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    cpu_req = 0;
    chk("held req acks in 8 cycles", acks, 4);
    repeat (3) @(negedge clk);

    run_fill('h1FFE, 4, 'hFFFF, 0, -1, nb);
    chk("wrap fill busy cycles", nb, 4);
    @(negedge clk);
    chk("wrap word 0x1ffe", int'(vram[13'h1ffe]), 'hFFFF);
    chk("wrap word 0x0001", int'(vram[13'h0001]), 'hFFFF);
    chk("word 0x0002 untouched", int'(vram[13'h0002]), v);

    run_fill('h40, 0, 'h7777, 0, -1, nb);
    chk("len 0 busy cycles", nb, 0);

    run_fill('h50, 8, 'h3C3C, 0, 2, nb);
    chk("restart ignored busy cycles", nb, 8);
    @(negedge clk);
    chk("restart ignored word 0x57", int'(vram[13'h57]), 'h3C3C);

    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0;
    run_fill(0, 6, 'hC3C3, 1, -1, nb);
    chk("contended fill busy cycles", nb, 12);
    cpu_req = 0;
    repeat (4) @(negedge clk);

    @(negedge clk);
    fill_start = 1; fill_base = 13'h200; fill_len = 14'd10; fill_value = 16'h5A5A;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      fill_start = 0;
      if (scr_load) n++;
    end
    chk("writes before reset", n, 3);
    #2 reset = 1;
    #1 chk("async reset mid-fill outputs zero", outs_nonzero(), 0);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    repeat (6) begin
      @(negedge clk);
      chk("no scr_load after reset", int'(scr_load), 0);
    end
    run_fill('h300, 5, 'h0F0F, 0, -1, nb);
    chk("fill after reset busy cycles", nb, 5);
    @(negedge clk);
    chk("fill after reset word 0x300", int'(vram[13'h300]), 'h0F0F);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!cpu_req || cpu_ack) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 47) - 16);
        cpu_wdata = 16'($urandom);
      end
      fill_start = ($urandom_range(0, 99) < 8);
      fill_base  = 13'($urandom_range(0, 40) - 8);
      fill_len   = 14'($urandom_range(0, 12));
      fill_value = 16'($urandom);
    end
    idle_inputs();
    for (int i = 0; i < 40 && fill_busy; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("ack queue drained", q_ack.size(), 0);
    chk("write queue drained", q_wr.size(), 0);
    chk("read queue drained", q_rd.size(), 0);
    chk("done queue drained", q_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_vram_arbiter.md
# screen_vram_arbiter

Shares the single 13-bit-address / 16-bit-data VRAM port of the 512x256 monochrome screen between the Hack CPU memory-mapped path and a built-in rectangular-free linear fill engine, used for clear-screen and band fills. Sits between the CPU memory decoder and the screen's `in` / `load` / `address` / `out` port on the CPU clock domain. The video scan-out side of the screen is untouched.

## Interface
Parameters:
- `ADDR_W`, 13, VRAM word address width; 8192 words.
- `DATA_W`, 16, VRAM word width.

Ports:
- `clk`  in  1  system (CPU) clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; fields below valid while high.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  13  CPU word address.
- `cpu_wdata`  in  16  CPU write data.
- `cpu_ack`  out  1  one-cycle pulse; request accepted and issued to VRAM.
- `cpu_rdata`  out  16  read data; valid while `cpu_rvalid` is high.
- `cpu_rvalid`  out  1  one-cycle pulse for a completed read.
- `fill_start`  in  1  start a fill; ignored while `fill_busy` is high.
- `fill_base`  in  13  first fill address.
- `fill_len`  in  14  word count, 0 to 8192.
- `fill_value`  in  16  word written at every fill address.
- `fill_busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse after the last fill write is issued.
- `scr_in`  out  16  to the screen's `in` port.
- `scr_load`  out  1  to the screen's `load` port.
- `scr_address`  out  13  to the screen's `address` port.
- `scr_out`  in  16  from the screen's `out` port; registered by the screen, 1-cycle read latency.

## Operation
- All outputs are registered.
- **Reset values:**
  - Every output is 0.
  - Fill state machine is in IDLE.
  - Internal pointer and count are 0.
- **Fill state machine:**
  - IDLE to FILL on `fill_start` with `fill_len != 0`. On that edge, latch `ptr = fill_base`, `remaining = fill_len`, and `value = fill_value`.
  - `fill_start` with `fill_len == 0` is a no-op. `fill_busy` stays 0 and `fill_done` pulses on the next cycle.
  - In FILL, each granted fill slot does the following:
    - writes `value` at `ptr`;
    - increments `ptr` modulo 8192 (8191 wraps to 0);
    - decrements `remaining`.
  - The slot that issues the write with `remaining == 1` returns the machine to IDLE. `fill_busy` falls and `fill_done` pulses on the same edge.
  - `fill_start` while in FILL is ignored, and the latched parameters are unchanged.
- **Arbitration, evaluated every edge:**
  - The CPU has priority when `cpu_req == 1` and `cpu_ack == 0`.
  - A CPU request is never granted on an edge where `cpu_ack` is currently 1. This gives the requester one cycle to drop or change `cpu_req`.
  - Otherwise, if in FILL, the fill engine is granted.
  - Otherwise there is no grant.
  - Result under back-to-back CPU traffic: CPU and fill alternate, each getting at most one slot in two cycles.
- **CPU grant:**
  - `scr_address <= cpu_addr`, `scr_load <= cpu_we`, `scr_in <= cpu_wdata`, `cpu_ack <= 1`.
  - For a read, the block records a pending read tag for the next edge.
- **Fill grant:** `scr_address <= ptr`, `scr_load <= 1`, `scr_in <= value`.
- **No grant:**
  - `scr_load <= 0`.
  - `scr_address` and `scr_in` hold their values.
- **Read return:** two edges after a CPU read grant, `cpu_rdata <= scr_out` and `cpu_rvalid <= 1` for one cycle.
  - At most one read is in flight per 2 cycles, so the tag needs only a 2-stage shift.
- **Write/read ordering:** a CPU read issued after a fill write to the same address returns the filled value, because the port is strictly in grant order.
- **Asynchronous reset mid-fill:**
  - The fill aborts with no `fill_done`.
  - Any pending `cpu_rvalid` is dropped.
  - `scr_load` deasserts immediately.

## Timing
- **CPU request** with `cpu_req` sampled high at edge k, and no fill contention:
  - `cpu_ack` and the screen drive are high in cycle k to k+1.
  - The screen samples at edge k+1.
  - For a read, `cpu_rvalid` and `cpu_rdata` are high in cycle k+2 to k+3.
  - Total read latency: 3 edges from request sample to data registered.
- **Fill:**
  - `fill_start` at edge k, then the first write is driven at edge k+1, unless the CPU wins that slot.
  - Uncontended fill of N words: `fill_busy` is high for N cycles and `fill_done` pulses at edge k+N.
  - Worst case with the CPU saturating: 2N cycles.
- **Full clear:** `fill_len = 8192` from base 0 completes in 8192 cycles uncontended.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge; after release, IDLE with no `scr_load`.
- **CPU write then read, no fill:**
  - Write `0xA5A5` to address `0x0100`, then read `0x0100`.
  - Required: `cpu_ack` one edge after each request; `cpu_rvalid` 2 edges after the read ack with `cpu_rdata == 0xA5A5`.
  - Holding `cpu_req` high gives one ack per 2 cycles.
- **Fill with wrap:**
  - `fill_base = 0x1FFE`, `fill_len = 4`, `fill_value = 0xFFFF`.
  - Required: writes to `0x1FFE`, `0x1FFF`, `0x0000`, `0x0001`; `fill_busy` high for 4 cycles; exactly one `fill_done` pulse; `0x0002` unchanged.
- **Contention:**
  - Start a 6-word fill while the CPU issues continuous reads of address 0.
  - Required: grants alternate CPU/fill; fill completes in 12 cycles; every read returns the pre-fill or post-fill value consistent with grant order.
- **Edge cases:**
  - `fill_len = 0` -> no writes; `fill_done` pulses one cycle later; `fill_busy` never rises.
  - `fill_start` during an active fill -> ignored; the original length and value complete.
- **Reset during fill:** assert reset after 3 of 10 fill writes -> no `fill_done`; no further `scr_load`; a new fill after release starts from the new `fill_base`.
